ppu_stat: RTL and testbench

- Consumer of the PPU engine's timing counters (lx, ly) and the lcdc.ena bit.
- Derives the current PPU mode and the LY==LYC coincidence flag.
- Owns the STAT and LYC registers on the PPU register bus, alongside ppu_ctrl.
- Raises one-cycle STAT and VBlank interrupt-request pulses toward the interrupt controller.

---
 rtl/ppu_stat_pkg.sv | 35 +++
 rtl/ppu_stat_mode_decode.sv | 17 +
 rtl/ppu_stat.sv | 88 ++++++++
 tb/tb_ppu_stat.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_stat_pkg.sv
// Shared PPU definitions: register map, mode encoding, STAT layout and line timing.
package ppu_stat_pkg;

  localparam logic [8:0] OAM_END   = 9'd80;
  localparam logic [8:0] XFER_END  = 9'd252;
  localparam logic [7:0] VBLANK_LY = 8'd144;

  typedef enum logic [3:0] {
    REG_LCDC = 4'h0,
    REG_STAT = 4'h1,
    REG_LYC  = 4'h5
  } ppu_reg_t;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } ppu_mode_t;

  typedef struct packed {
    logic      one;
    logic      lyc_sel;
    logic      oam_sel;
    logic      vbl_sel;
    logic      hbl_sel;
    logic      coinc;
    ppu_mode_t mode;
  } stat_t;

  function automatic logic stat_reg_mapped(input logic [3:0] addr);
    return (addr == REG_STAT) || (addr == REG_LYC);
  endfunction

endpackage

// File: rtl/ppu_stat_mode_decode.sv
// Combinational lx/ly -> PPU mode; shared with the pixel FIFO.
module ppu_mode_decode
  import ppu_stat_pkg::*;
(
  input  logic [8:0] lx,
  input  logic [7:0] ly,
  output ppu_mode_t  mode
);

  always_comb begin
    if (ly >= VBLANK_LY)     mode = VBLANK;
    else if (lx < OAM_END)   mode = OAM;
    else if (lx < XFER_END)  mode = XFER;
    else                     mode = HBLANK;
  end

endmodule

// File: rtl/ppu_stat.sv
// STAT/LYC registers, registered PPU mode and coincidence, STAT/VBlank irq pulses.
module ppu_stat
  import ppu_stat_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_ena,
  input  logic [8:0] lx,
  input  logic [7:0] ly,
  input  logic [3:0] reg_addr,
  input  logic [7:0] reg_in,
  input  logic       reg_write,
  output logic [7:0] reg_out,
  output logic       reg_hit,
  output logic [1:0] mode,
  output logic       stat_irq,
  output logic       vblank_irq
);

  logic [3:0] sel;          // {lyc, oam, vblank, hblank} interrupt selects
  logic [7:0] lyc;
  ppu_mode_t  mode_q;
  ppu_mode_t  mode_next;
  logic       coinc;
  logic       stat_line;
  logic       stat_line_q;
  logic       wr_stat;
  logic       wr_lyc;
  stat_t      stat_rd;

  ppu_mode_decode u_mode_decode (
    .lx   (lx),
    .ly   (ly),
    .mode (mode_next)
  );

  assign wr_stat = reg_write && (reg_addr == REG_STAT);
  assign wr_lyc  = reg_write && (reg_addr == REG_LYC);
  assign reg_hit = stat_reg_mapped(reg_addr);
  assign mode    = mode_q;

  // Evaluated from registered state, so a same-cycle register write is not yet visible.
  assign stat_line = (sel[3] & coinc)
                   | (sel[2] & (mode_q == OAM))
                   | (sel[1] & (mode_q == VBLANK))
                   | (sel[0] & (mode_q == HBLANK));

  assign stat_rd = '{one: 1'b1, lyc_sel: sel[3], oam_sel: sel[2], vbl_sel: sel[1],
                     hbl_sel: sel[0], coinc: coinc, mode: mode_q};

  // NOTE: default assignment first keeps this always_comb free of inferred latches.
  always_comb begin
    reg_out = 8'h00;
    if (reg_addr == REG_STAT)     reg_out = stat_rd;
    else if (reg_addr == REG_LYC) reg_out = lyc;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= 4'h0;
      lyc         <= 8'h00;
      mode_q      <= HBLANK;
      coinc       <= 1'b0;
      stat_line_q <= 1'b0;
      stat_irq    <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      if (wr_stat) sel <= reg_in[6:3];
      if (wr_lyc)  lyc <= reg_in;

      if (lcd_ena) begin
        mode_q      <= mode_next;
        coinc       <= (ly == lyc);
        stat_line_q <= stat_line;
        stat_irq    <= stat_line & ~stat_line_q;
        vblank_irq  <= (mode_next == VBLANK) && (mode_q != VBLANK);
      end else begin
        // Display off: coinc freezes, and the cleared edge history lets re-enable fire once.
        mode_q      <= HBLANK;
        stat_line_q <= 1'b0;
        stat_irq    <= 1'b0;
        vblank_irq  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_stat.sv
// Self-checking bench for ppu_stat: directed scenarios plus a randomized phase vs a reference model.
module tb_ppu_stat;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       lcd_ena   = 1'b0;
  logic [8:0] lx        = '0;
  logic [7:0] ly        = '0;
  logic [3:0] reg_addr  = '0;
  logic [7:0] reg_in    = '0;
  logic       reg_write = 1'b0;
  logic [7:0] reg_out;
  logic       reg_hit;
  logic [1:0] mode;
  logic       stat_irq;
  logic       vblank_irq;

  int tests = 0;
  int fails = 0;
  int n_sirq = 0;
  int n_virq = 0;

  // Reference state: what the PPU status should look like after each clock.
  logic [3:0] m_sel;
  logic [7:0] m_lyc;
  logic [1:0] m_mode;
  logic       m_coinc;
  logic       m_prev;
  logic       m_sirq;
  logic       m_virq;

  ppu_stat dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_ena    (lcd_ena),
    .lx         (lx),
    .ly         (ly),
    .reg_addr   (reg_addr),
    .reg_in     (reg_in),
    .reg_write  (reg_write),
    .reg_out    (reg_out),
    .reg_hit    (reg_hit),
    .mode       (mode),
    .stat_irq   (stat_irq),
    .vblank_irq (vblank_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_mode(input int x, input int y);
    if (y >= 144) return 2'd1;
    if (x < 80)   return 2'd2;
    if (x < 252)  return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic cond_line(input logic [3:0] s, input logic c, input logic [1:0] md);
    logic [3:0] hits;
    hits = {c, md == 2'd2, md == 2'd1, md == 2'd0};
    return |(s & hits);
  endfunction

  task automatic model_reset();
    m_sel = 4'h0; m_lyc = 8'h00; m_mode = 2'd0; m_coinc = 1'b0;
    m_prev = 1'b0; m_sirq = 1'b0; m_virq = 1'b0;
  endtask

  task automatic read_back();
    reg_write = 1'b0;
    reg_addr = 4'h1;
    #1;
    check("stat_read", reg_out, {1'b1, m_sel, m_coinc, m_mode});
    check("stat_hit", {7'd0, reg_hit}, 8'd1);
    reg_addr = 4'h5;
    #1;
    check("lyc_read", reg_out, m_lyc);
  endtask

  // One clock: model consumes the inputs presented before the edge, then outputs are compared.
  task automatic tick();
    logic line;
    @(posedge clk);
    line   = cond_line(m_sel, m_coinc, m_mode);
    m_sirq = lcd_ena && line && !m_prev;
    m_virq = lcd_ena && (ref_mode(lx, ly) == 2'd1) && (m_mode != 2'd1);
    m_prev = lcd_ena && line;
    if (lcd_ena) m_coinc = (ly == m_lyc);
    m_mode = lcd_ena ? ref_mode(lx, ly) : 2'd0;
    if (reg_write && reg_addr == 4'h1) m_sel = reg_in[6:3];
    if (reg_write && reg_addr == 4'h5) m_lyc = reg_in;
    #1;
    reg_write = 1'b0;
    n_sirq += int'(stat_irq);
    n_virq += int'(vblank_irq);
    check("mode", {6'd0, mode}, {6'd0, m_mode});
    check("stat_irq", {7'd0, stat_irq}, {7'd0, m_sirq});
    check("vblank_irq", {7'd0, vblank_irq}, {7'd0, m_virq});
    read_back();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    reg_addr = a; reg_in = d; reg_write = 1'b1;
    tick();
  endtask

  initial begin
    int base_s, base_v;
    model_reset();

    // Reset state
    #12;
    check("rst_mode", {6'd0, mode}, 8'd0);
    check("rst_sirq", {7'd0, stat_irq}, 8'd0);
    check("rst_virq", {7'd0, vblank_irq}, 8'd0);
    reg_addr = 4'h1; #1; check("rst_stat", reg_out, 8'h80);
    reg_addr = 4'h5; #1; check("rst_lyc", reg_out, 8'h00);
    reg_addr = 4'h3; #1; check("unmapped_hit", {7'd0, reg_hit}, 8'd0);
    rst_n = 1'b1;

    // Mode sweep over one visible line
    lcd_ena = 1'b1; ly = 8'd10;
    for (int x = 0; x < 456; x++) begin lx = 9'(x); tick(); end
    check("sweep_no_sirq", 8'(n_sirq), 8'd0);

    // LY==LYC coincidence interrupt
    lx = 9'd100; ly = 8'd41;
    wr(4'h5, 8'h2A);
    wr(4'h1, 8'h40);
    wr(4'h3, 8'hFF);
    base_s = n_sirq;
    tick();
    ly = 8'd42;
    tick();
    check("coinc_set", reg_out, 8'h2A);
    reg_addr = 4'h1; #1; check("coinc_bit", reg_out & 8'h04, 8'h04);
    tick();
    check("coinc_irq", {7'd0, stat_irq}, 8'd1);
    tick();
    ly = 8'd43;
    tick(); tick();
    check("coinc_once", 8'(n_sirq - base_s), 8'd1);
    reg_addr = 4'h1; #1; check("coinc_clr", reg_out & 8'h04, 8'h00);

    // Mode 0 + mode 2 selects across a line boundary
    wr(4'h1, 8'h28);
    base_s = n_sirq;
    ly = 8'd50;
    for (int x = 0; x < 456; x++) begin lx = 9'(x); tick(); end
    check("line_two_irqs", 8'(n_sirq - base_s), 8'd2);
    base_s = n_sirq;
    ly = 8'd51;
    for (int x = 0; x < 10; x++) begin lx = 9'(x); tick(); end
    check("line_blocked", 8'(n_sirq - base_s), 8'd0);

    // VBlank entry
    wr(4'h1, 8'h10);
    base_s = n_sirq; base_v = n_virq;
    for (int y = 140; y < 154; y++) begin
      ly = 8'(y);
      lx = 9'd0;   tick();
      lx = 9'd100; tick();
      lx = 9'd300; tick();
      lx = 9'd455; tick();
    end
    ly = 8'd0; lx = 9'd0; tick(); tick();
    check("vblank_once", 8'(n_virq - base_v), 8'd1);
    check("vbl_stat_once", 8'(n_sirq - base_s), 8'd1);

    // Display off mid-transfer, then back on
    ly = 8'd60; lx = 9'd120; tick();
    check("xfer_mode", {6'd0, mode}, 8'd3);
    lcd_ena = 1'b0;
    tick(); tick();
    wr(4'h1, 8'hFF);
    reg_addr = 4'h1; #1;
    check("off_stat", reg_out, 8'hF8 | {5'd0, m_coinc, 2'b00});
    check("off_mode", {6'd0, mode}, 8'd0);
    tick();
    lcd_ena = 1'b1;
    for (int i = 0; i < 4; i++) begin lx = 9'(120 + i); tick(); end
    check("on_mode", {6'd0, mode}, 8'd3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      lcd_ena = ($urandom_range(0, 15) != 0);
      ly = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(138, 153)) : 8'($urandom_range(0, 153));
      lx = 9'($urandom_range(0, 455));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: reg_addr = 4'h1;
          1: reg_addr = 4'h5;
          2: reg_addr = 4'h3;
          default: reg_addr = 4'h0;
        endcase
        reg_in = (reg_addr == 4'h5) ? 8'($urandom_range(138, 153)) : 8'($urandom_range(0, 255));
        reg_write = 1'b1;
      end
      tick();
    end

    // Asynchronous reset mid-line
    lcd_ena = 1'b1; ly = 8'd70; lx = 9'd200; tick(); tick();
    #2 rst_n = 1'b0;
    reg_addr = 4'h1;
    #1;
    check("arst_mode", {6'd0, mode}, 8'd0);
    check("arst_sirq", {7'd0, stat_irq}, 8'd0);
    check("arst_virq", {7'd0, vblank_irq}, 8'd0);
    check("arst_stat", reg_out, 8'h80);
    reg_addr = 4'h5; #1; check("arst_lyc", reg_out, 8'h00);
    model_reset();
    rst_n = 1'b1;
    for (int x = 200; x < 260; x++) begin lx = 9'(x); tick(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
